// File: rtl/or1k_store_buffer_drain.sv
// Drains committed stores from the LSU store buffer onto dbus one at a time; 3 cycles per store minimum.
// Backpressure: a store holds dbus_req_o until ack/err/timeout, and an error stalls draining until err_ack_i.
module or1k_store_buffer_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int BUS_TIMEOUT          = 0,
  parameter int TIMEOUT_WIDTH        = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic                              sb_atomic_i,
  input  logic                              atomic_reserve_i,
  output logic                              atomic_done_o,
  output logic                              atomic_fail_o,
  output logic                              dbus_req_o,
  output logic                              dbus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
  input  logic                              dbus_ack_i,
  input  logic                              dbus_err_i,
  input  logic                              flush_i,
  output logic                              flush_done_o,
  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_adr_o,
  input  logic                              err_ack_i,
  output logic                              busy_o
);

  localparam int                       BW        = OPTION_OPERAND_WIDTH / 8;
  localparam int                       TO_LAST_I = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST   = TIMEOUT_WIDTH'(TO_LAST_I);
  localparam bit                       TO_EN     = (BUS_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, ERR} state_t;

  state_t                          state;
  logic [OPTION_OPERAND_WIDTH-1:0] ent_adr;
  logic [OPTION_OPERAND_WIDTH-1:0] ent_dat;
  logic [OPTION_OPERAND_WIDTH-1:0] ent_pc;
  logic [BW-1:0]                   ent_bsel;
  logic                            ent_atomic;
  logic [TIMEOUT_WIDTH-1:0]        to_cnt;
  logic                            timeout_hit;

  assign timeout_hit = TO_EN && (to_cnt == TO_LAST);

  // Pop is gated by rst so nothing is requested from the buffer while held in reset.
  assign sb_read_o   = rst && (state == IDLE) && !sb_empty_i;
  assign dbus_req_o  = (state == WRITE);
  assign dbus_we_o   = (state == WRITE);
  assign dbus_adr_o  = ent_adr;
  assign dbus_dat_o  = ent_dat;
  assign dbus_bsel_o = ent_bsel;
  assign store_err_o = (state == ERR);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ent_adr       <= '0;
      ent_dat       <= '0;
      ent_pc        <= '0;
      ent_bsel      <= '0;
      ent_atomic    <= 1'b0;
      to_cnt        <= '0;
      atomic_done_o <= 1'b0;
      atomic_fail_o <= 1'b0;
      flush_done_o  <= 1'b0;
      err_pc_o      <= '0;
      err_adr_o     <= '0;
    end else begin
      atomic_done_o <= 1'b0;
      atomic_fail_o <= 1'b0;
      flush_done_o  <= flush_i && (state == IDLE) && sb_empty_i;
      case (state)
        IDLE: begin
          if (!sb_empty_i) state <= LOAD;
        end
        LOAD: begin
          ent_adr    <= sb_adr_i;
          ent_dat    <= sb_dat_i;
          ent_pc     <= sb_pc_i;
          ent_bsel   <= sb_bsel_i;
          ent_atomic <= sb_atomic_i;
          to_cnt     <= '0;
          if (sb_atomic_i && !atomic_reserve_i) begin
            atomic_fail_o <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          // err wins over a simultaneous ack, so an erroring swa never reports done
          if (dbus_err_i || (!dbus_ack_i && timeout_hit)) begin
            err_pc_o  <= ent_pc;
            err_adr_o <= ent_adr;
            state     <= ERR;
          end else if (dbus_ack_i) begin
            atomic_done_o <= ent_atomic;
            state         <= IDLE;
          end else begin
            to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
          end
        end
        ERR: begin
          if (err_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/or1k_store_buffer_drain.md
Name: or1k_store_buffer_drain

Overview:
- Sequencer that pops committed stores from the LSU store buffer FIFO and performs them on the data bus, one at a time, in order.
- Handles atomic (swa) entries against the load-link reservation.
- Provides a drain/flush handshake for msync and sync.
- Reports bus errors and bus timeouts with the PC and address of the faulting store.
- Sits between the store buffer's read port and the dbus master interface.

Parameters:
OPTION_OPERAND_WIDTH, 32, data/address/PC width.
BUS_TIMEOUT, 0, cycles to wait for ack/err before declaring a timeout error; 0 disables the timeout.
TIMEOUT_WIDTH, 8, width of the timeout counter; BUS_TIMEOUT must be < 2**TIMEOUT_WIDTH.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset, asynchronous, active-low; rst=0 resets all state immediately.
sb_empty_i  in  1  store buffer empty.
sb_read_o  out  1  pop one store buffer entry (single-cycle pulse).
sb_adr_i  in  OPTION_OPERAND_WIDTH  popped address; valid the cycle after sb_read_o.
sb_dat_i  in  OPTION_OPERAND_WIDTH  popped data; same timing as sb_adr_i.
sb_bsel_i  in  OPTION_OPERAND_WIDTH/8  popped byte select; same timing.
sb_pc_i  in  OPTION_OPERAND_WIDTH  popped PC; same timing.
sb_atomic_i  in  1  popped entry is atomic; same timing.
atomic_reserve_i  in  1  load-link reservation still valid.
atomic_done_o  out  1  pulse: atomic store completed on the bus.
atomic_fail_o  out  1  pulse: atomic store dropped because the reservation was lost.
dbus_req_o  out  1  bus write request.
dbus_we_o  out  1  write enable; high whenever dbus_req_o is high.
dbus_adr_o  out  OPTION_OPERAND_WIDTH  bus address.
dbus_dat_o  out  OPTION_OPERAND_WIDTH  bus write data.
dbus_bsel_o  out  OPTION_OPERAND_WIDTH/8  bus byte select.
dbus_ack_i  in  1  bus transfer done.
dbus_err_i  in  1  bus transfer error.
flush_i  in  1  level request: stop accepting and report when drained.
flush_done_o  out  1  flush complete.
store_err_o  out  1  level: faulting store pending.
err_pc_o  out  OPTION_OPERAND_WIDTH  PC of the faulting store.
err_adr_o  out  OPTION_OPERAND_WIDTH  address of the faulting store.
err_ack_i  in  1  exception unit has taken the error.
busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst=0): state=IDLE. All outputs are 0, and all latched entry and error registers are 0. An entry in flight at reset is discarded; no bus request is held.
- IDLE: if !sb_empty_i, drive sb_read_o=1 for one cycle and go to LOAD. Otherwise remain in IDLE.
- LOAD: capture sb_* into the entry registers.
  - Non-atomic entry: go to WRITE.
  - Atomic entry with atomic_reserve_i=1: go to WRITE.
  - Atomic entry with atomic_reserve_i=0: pulse atomic_fail_o, issue no bus cycle, return to IDLE.
- WRITE:
  - dbus_req_o=1 and dbus_we_o=1; dbus_adr_o, dbus_dat_o and dbus_bsel_o come from the entry registers and stay stable until the transfer terminates.
  - On dbus_err_i (takes priority over a simultaneous ack): go to ERR.
  - Else on dbus_ack_i: dbus_req_o=0 the next cycle, pulse atomic_done_o if the entry is atomic, go to IDLE.
  - ack and err are sampled only while dbus_req_o=1.
- Timeout:
  - The counter clears on entry to WRITE and increments each WRITE cycle with no ack/err.
  - If BUS_TIMEOUT!=0 and the counter reaches BUS_TIMEOUT-1 without ack/err, go to ERR and drop dbus_req_o.
- ERR:
  - store_err_o=1, with err_pc_o/err_adr_o holding the entry's PC and address. dbus_req_o=0.
  - No pops occur while in ERR.
  - On err_ack_i: clear store_err_o and return to IDLE; draining resumes with the next entry.
- Throughput: one store per 3 cycles minimum (IDLE, LOAD, WRITE with same-cycle ack). No back-to-back pop optimisation.
- Flush:
  - flush_done_o = flush_i & state==IDLE & sb_empty_i, registered; it rises 1 cycle after the condition holds.
  - flush_i does not block draining.
  - If an error occurs while flushing, flush_done_o stays 0 until err_ack_i and the buffer is empty.
- sb_read_o is never asserted when sb_empty_i=1, and never in any state other than IDLE.
- busy_o = (state != IDLE).

Test Plan:
1. Push 3 non-atomic stores (adr 0x100/0x104/0x108, dat 0xA/0xB/0xC) with 1-cycle ack -> three bus writes in order with matching adr/dat/bsel, exactly 3 sb_read_o pulses, busy_o=0 at the end.
2. Atomic entry with atomic_reserve_i=1, then a second atomic entry with atomic_reserve_i=0 -> first: bus write plus atomic_done_o pulse; second: no dbus_req_o, one atomic_fail_o pulse.
3. dbus_err_i on the 2nd of 3 stores (pc 0x2004, adr 0x104) -> store_err_o=1, err_pc_o=0x2004, err_adr_o=0x104, no pops until err_ack_i; then the 3rd store completes.
4. BUS_TIMEOUT=8, ack never arrives -> dbus_req_o high for exactly 8 cycles, then store_err_o=1 with the entry's PC/address.
5. flush_i held high with 2 entries queued -> flush_done_o=0 until both acks, then 1 one cycle after the buffer is empty and IDLE; simultaneous ack and err on one transfer -> error path taken, no atomic_done_o.
6. Assert rst=0 mid-WRITE -> dbus_req_o drops immediately, all outputs 0; after release with the buffer empty, state is IDLE with no spurious sb_read_o.
